// File: rtl/mc_control_unit_if.sv
// Instruction-field inputs and datapath control outputs of mc_control_unit.
// master drives the decoded instruction fields, slave is the control unit.
interface mc_ctrl_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       Mul;

  logic [1:0] FlagW;
  logic       PCS;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       IRWrite;
  logic       AdrSrc;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic [3:0] ALUControl;
  logic       Illegal;

  modport master (
    output Op, Funct, Rd, Mul,
    input  FlagW, PCS, NextPC, RegW, MemW, IRWrite, AdrSrc,
    input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, Illegal
  );

  modport slave (
    input  Op, Funct, Rd, Mul,
    output FlagW, PCS, NextPC, RegW, MemW, IRWrite, AdrSrc,
    output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, Illegal
  );
endinterface

// File: rtl/mc_control_unit.sv
// Multicycle ARM control unit: main FSM, ALU decoder, PC-write and instruction decode.
// Iterative multiply (Mul input, MULEX state, counter) is built only when DECODE_MUL_EN is defined.
//
// state    | meaning
// FETCH    | read instruction, PC <- PC+4
// DECODE   | read registers, compute PC+8
// MEMADR   | compute load/store address
// MEMREAD  | read data memory
// MEMWB    | write loaded word to register file
// MEMWRITE | write data memory
// EXECUTER | ALU op, register operand
// EXECUTEI | ALU op, immediate operand
// MULEX    | iterative multiply, MUL_CYCLES cycles
// ALUWB    | write ALU result (suppressed for CMP/TST)
// BRANCH   | compute branch target and write PC
// UNKNOWN  | undefined Op, flag Illegal for one cycle
module mc_control_unit #(
  parameter int         MUL_CYCLES = 4,
  parameter logic [3:0] PC_REG     = 4'd15
) (
  input  logic      clk,
  input  logic      reset,
  mc_ctrl_if.slave  ctrl
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_MULEX    = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_UNKNOWN  = 4'd11
  } state_t;

  generate
    if ((MUL_CYCLES < 1) || (MUL_CYCLES > 15)) begin : g_bad_mul_cycles
      $error("mc_control_unit: MUL_CYCLES must be in 1..15");
    end
  endgenerate

  state_t     r_state;
  state_t     w_next;
  logic [3:0] w_cmd;
  logic       w_s;
  logic       w_mul_req;
  logic       w_mul_last;
  logic       w_alu_op;
  logic       w_branch;
  logic       w_no_write;
  logic       w_regw;
  logic       w_memw;
  logic       w_irwrite;
  logic       w_nextpc;
  logic       w_adrsrc;
  logic       w_illegal;
  logic [1:0] w_resultsrc;
  logic [1:0] w_alusrca;
  logic [1:0] w_alusrcb;
  logic [3:0] w_alucontrol;
  logic [1:0] w_flagw;

  assign w_cmd      = ctrl.Funct[4:1];
  assign w_s        = ctrl.Funct[0];
  assign w_no_write = (w_cmd == 4'b1010) || (w_cmd == 4'b1000);

`ifdef DECODE_MUL_EN
  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

  logic [3:0] r_mul_cnt;

  assign w_mul_req  = ctrl.Mul;
  assign w_mul_last = (r_mul_cnt == 4'd0);

  // Counter is loaded on the DECODE->MULEX edge and counts down to the exit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mul_cnt <= 4'd0;
    end else if ((r_state == S_DECODE) && (w_next == S_MULEX)) begin
      r_mul_cnt <= MUL_LOAD;
    end else if ((r_state == S_MULEX) && (r_mul_cnt != 4'd0)) begin
      r_mul_cnt <= r_mul_cnt - 4'd1;
    end
  end
`else
  assign w_mul_req  = 1'b0;
  assign w_mul_last = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = S_FETCH;
    w_irwrite   = 1'b0;
    w_nextpc    = 1'b0;
    w_adrsrc    = 1'b0;
    w_alusrca   = 2'b00;
    w_alusrcb   = 2'b00;
    w_resultsrc = 2'b00;
    w_regw      = 1'b0;
    w_memw      = 1'b0;
    w_alu_op    = 1'b0;
    w_branch    = 1'b0;
    w_illegal   = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_irwrite   = 1'b1;
        w_nextpc    = 1'b1;
        w_alusrca   = 2'b01;
        w_alusrcb   = 2'b10;
        w_resultsrc = 2'b10;
        w_next      = S_DECODE;
      end
      S_DECODE: begin
        w_alusrca   = 2'b01;
        w_alusrcb   = 2'b10;
        w_resultsrc = 2'b10;
        case (ctrl.Op)
          2'b00: begin
            if (w_mul_req)           w_next = S_MULEX;
            else if (ctrl.Funct[5])  w_next = S_EXECUTEI;
            else                     w_next = S_EXECUTER;
          end
          2'b01:   w_next = S_MEMADR;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_UNKNOWN;
        endcase
      end
      S_MEMADR: begin
        w_alusrcb = 2'b01;
        w_next    = ctrl.Funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_adrsrc = 1'b1;
        w_next   = S_MEMWB;
      end
      S_MEMWB: begin
        w_resultsrc = 2'b01;
        w_regw      = 1'b1;
      end
      S_MEMWRITE: begin
        w_adrsrc = 1'b1;
        w_memw   = 1'b1;
      end
      S_EXECUTER: begin
        w_alu_op = 1'b1;
        w_next   = S_ALUWB;
      end
      S_EXECUTEI: begin
        w_alusrcb = 2'b01;
        w_alu_op  = 1'b1;
        w_next    = S_ALUWB;
      end
      S_MULEX: begin
        w_alu_op = 1'b1;
        w_next   = w_mul_last ? S_ALUWB : S_MULEX;
      end
      S_ALUWB: begin
        w_regw = ~w_no_write;
      end
      S_BRANCH: begin
        w_alusrca   = 2'b10;
        w_alusrcb   = 2'b01;
        w_resultsrc = 2'b10;
        w_branch    = 1'b1;
      end
      S_UNKNOWN: begin
        w_illegal = 1'b1;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  always_comb begin
    w_alucontrol = 4'b0000;
    w_flagw      = 2'b00;
    if (w_alu_op) begin
      case (w_cmd)
        4'b0100: w_alucontrol = 4'b0000;
        4'b0010: w_alucontrol = 4'b0001;
        4'b1010: w_alucontrol = 4'b0001;
        4'b0000: w_alucontrol = 4'b0010;
        4'b1000: w_alucontrol = 4'b0010;
        4'b1100: w_alucontrol = 4'b0011;
        4'b0001: w_alucontrol = 4'b0100;
        4'b1101: w_alucontrol = 4'b0101;
        default: w_alucontrol = 4'b0000;
      endcase
      w_flagw[1] = w_s;
      w_flagw[0] = w_s & ((w_cmd == 4'b0100) || (w_cmd == 4'b0010) || (w_cmd == 4'b1010));
      // Multiply updates NZ only, and only once the product is complete.
      if (r_state == S_MULEX) begin
        w_alucontrol = 4'b0110;
        w_flagw      = {w_s & w_mul_last, 1'b0};
      end
    end
  end

  assign ctrl.IRWrite    = w_irwrite;
  assign ctrl.NextPC     = w_nextpc;
  assign ctrl.AdrSrc     = w_adrsrc;
  assign ctrl.ALUSrcA    = w_alusrca;
  assign ctrl.ALUSrcB    = w_alusrcb;
  assign ctrl.ResultSrc  = w_resultsrc;
  assign ctrl.RegW       = w_regw;
  assign ctrl.MemW       = w_memw;
  assign ctrl.Illegal    = w_illegal;
  assign ctrl.ALUControl = w_alucontrol;
  assign ctrl.FlagW      = w_flagw;
  assign ctrl.PCS        = ((ctrl.Rd == PC_REG) & w_regw) | w_branch;
  assign ctrl.ImmSrc     = ctrl.Op;
  assign ctrl.RegSrc     = {(ctrl.Op == 2'b01), (ctrl.Op == 2'b10)};

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: the driver queues hand-derived per-cycle control
// vectors, a negedge monitor pops and compares them against the DUT outputs.
module tb_mc_control_unit;

  localparam int MC = 4;

  typedef struct packed {
    logic       irw;
    logic       npc;
    logic       adr;
    logic [1:0] asa;
    logic [1:0] asb;
    logic [1:0] rs;
    logic       regw;
    logic       memw;
    logic       pcs;
    logic [3:0] aluc;
    logic [1:0] flagw;
    logic       ill;
    logic [1:0] imm;
    logic [1:0] regsrc;
  } ctl_t;

  typedef struct {
    string nm;
    ctl_t  v;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  mc_ctrl_if ctrl();

  mc_control_unit #(.MUL_CYCLES(MC), .PC_REG(4'd15)) dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vectors, one helper per FSM state; fields not set stay 0.
  function automatic ctl_t base(input logic [1:0] op);
    ctl_t v = '0;
    v.imm    = op;
    v.regsrc = {(op == 2'b01), (op == 2'b10)};
    return v;
  endfunction

  function automatic ctl_t fetch_v(input logic [1:0] op);
    ctl_t v = base(op);
    v.irw = 1'b1; v.npc = 1'b1; v.asa = 2'b01; v.asb = 2'b10; v.rs = 2'b10;
    return v;
  endfunction

  function automatic ctl_t decode_v(input logic [1:0] op);
    ctl_t v = base(op);
    v.asa = 2'b01; v.asb = 2'b10; v.rs = 2'b10;
    return v;
  endfunction

  function automatic ctl_t exec_v(input logic imm, input logic [3:0] aluc, input logic [1:0] fw);
    ctl_t v = base(2'b00);
    v.asb = imm ? 2'b01 : 2'b00; v.aluc = aluc; v.flagw = fw;
    return v;
  endfunction

  function automatic ctl_t mulex_v(input logic [1:0] fw);
    ctl_t v = base(2'b00);
    v.aluc = 4'b0110; v.flagw = fw;
    return v;
  endfunction

  function automatic ctl_t aluwb_v(input logic regw, input logic pcs);
    ctl_t v = base(2'b00);
    v.regw = regw; v.pcs = pcs;
    return v;
  endfunction

  function automatic ctl_t memadr_v();
    ctl_t v = base(2'b01);
    v.asb = 2'b01;
    return v;
  endfunction

  function automatic ctl_t memread_v();
    ctl_t v = base(2'b01);
    v.adr = 1'b1;
    return v;
  endfunction

  function automatic ctl_t memwb_v(input logic pcs);
    ctl_t v = base(2'b01);
    v.rs = 2'b01; v.regw = 1'b1; v.pcs = pcs;
    return v;
  endfunction

  function automatic ctl_t memwr_v();
    ctl_t v = base(2'b01);
    v.adr = 1'b1; v.memw = 1'b1;
    return v;
  endfunction

  function automatic ctl_t branch_v();
    ctl_t v = base(2'b10);
    v.asa = 2'b10; v.asb = 2'b01; v.rs = 2'b10; v.pcs = 1'b1;
    return v;
  endfunction

  function automatic ctl_t unk_v();
    ctl_t v = base(2'b11);
    v.ill = 1'b1;
    return v;
  endfunction

  task automatic set_instr(input logic [1:0] op, input logic [5:0] funct,
                           input logic [3:0] rd, input logic mul);
    ctrl.Op = op; ctrl.Funct = funct; ctrl.Rd = rd; ctrl.Mul = mul;
  endtask

  // Queue the expectation for the current cycle, then advance to just after the next edge.
  task automatic step(input string nm, input ctl_t v);
    exp_t e;
    e.nm = nm;
    e.v  = v;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run_dp(input string nm, input logic [5:0] funct, input logic [3:0] rd,
                        input logic [3:0] aluc, input logic [1:0] fw,
                        input logic regw, input logic pcs);
    set_instr(2'b00, funct, rd, 1'b0);
    step({nm, "_fetch"}, fetch_v(2'b00));
    step({nm, "_decode"}, decode_v(2'b00));
    step({nm, "_exec"}, exec_v(funct[5], aluc, fw));
    step({nm, "_aluwb"}, aluwb_v(regw, pcs));
  endtask

  // Multiply with S=1; cmd field 0000 writes back, so RegW=1 in ALUWB.
  task automatic run_mul(input string nm, input logic [3:0] rd, input logic pcs);
    set_instr(2'b00, 6'b000001, rd, 1'b1);
    step({nm, "_fetch"}, fetch_v(2'b00));
    step({nm, "_decode"}, decode_v(2'b00));
`ifdef DECODE_MUL_EN
    for (int i = 0; i < MC; i++)
      step($sformatf("%s_mulex%0d", nm, i + 1), mulex_v((i == MC - 1) ? 2'b10 : 2'b00));
`else
    step({nm, "_exec"}, exec_v(1'b0, 4'b0010, 2'b10));
`endif
    step({nm, "_aluwb"}, aluwb_v(1'b1, pcs));
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      ctl_t act;
      e   = exp_q.pop_front();
      act = {ctrl.IRWrite, ctrl.NextPC, ctrl.AdrSrc, ctrl.ALUSrcA, ctrl.ALUSrcB,
             ctrl.ResultSrc, ctrl.RegW, ctrl.MemW, ctrl.PCS, ctrl.ALUControl,
             ctrl.FlagW, ctrl.Illegal, ctrl.ImmSrc, ctrl.RegSrc};
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s: got %b required %b (irw npc adr asa asb rs regw memw pcs aluc flagw ill imm regsrc)",
                 e.nm, act, e.v);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    set_instr(2'b00, 6'b001001, 4'd1, 1'b0);
    @(posedge clk);
    #1;
    step("rst_hold_fetch", fetch_v(2'b00));
    reset = 1'b0;

    // ADD R1,R2,R3 with S=1; its FETCH is the first cycle after reset release
    step("add_fetch", fetch_v(2'b00));
    step("add_decode", decode_v(2'b00));
    step("add_exec", exec_v(1'b0, 4'b0000, 2'b11));
    step("add_aluwb", aluwb_v(1'b1, 1'b0));

    run_dp("cmp_pc", 6'b010101, 4'd15, 4'b0001, 2'b11, 1'b0, 1'b0);
    run_dp("tst_pc", 6'b010001, 4'd15, 4'b0010, 2'b10, 1'b0, 1'b0);
    run_dp("sub_s",  6'b000101, 4'd4,  4'b0001, 2'b11, 1'b1, 1'b0);
    run_dp("eor_s",  6'b000011, 4'd5,  4'b0100, 2'b10, 1'b1, 1'b0);
    run_dp("orr_i",  6'b111000, 4'd15, 4'b0011, 2'b00, 1'b1, 1'b1);
    run_dp("mov_i",  6'b111011, 4'd6,  4'b0101, 2'b10, 1'b1, 1'b0);
    run_dp("rsb_s",  6'b000111, 4'd7,  4'b0000, 2'b10, 1'b1, 1'b0);

    set_instr(2'b01, 6'b011001, 4'd15, 1'b0);
    step("ldr_fetch", fetch_v(2'b01));
    step("ldr_decode", decode_v(2'b01));
    step("ldr_memadr", memadr_v());
    step("ldr_memread", memread_v());
    step("ldr_memwb", memwb_v(1'b1));

    set_instr(2'b01, 6'b011000, 4'd2, 1'b0);
    step("str_fetch", fetch_v(2'b01));
    step("str_decode", decode_v(2'b01));
    step("str_memadr", memadr_v());
    step("str_memwrite", memwr_v());

    set_instr(2'b10, 6'b101000, 4'd0, 1'b0);
    step("b_fetch", fetch_v(2'b10));
    step("b_decode", decode_v(2'b10));
    step("b_branch", branch_v());

    set_instr(2'b11, 6'b000000, 4'd3, 1'b0);
    step("undef_fetch", fetch_v(2'b11));
    step("undef_decode", decode_v(2'b11));
    step("undef_unknown", unk_v());

    run_mul("mul", 4'd3, 1'b0);

    // reset in the 2nd execute cycle of a multiply aborts it before any write-back
    set_instr(2'b00, 6'b000001, 4'd15, 1'b1);
    step("mulrst_fetch", fetch_v(2'b00));
    step("mulrst_decode", decode_v(2'b00));
`ifdef DECODE_MUL_EN
    step("mulrst_mulex1", mulex_v(2'b00));
    reset = 1'b1;
    step("mulrst_mulex2", mulex_v(2'b00));
`else
    reset = 1'b1;
    step("mulrst_exec", exec_v(1'b0, 4'b0010, 2'b10));
`endif
    reset = 1'b0;
    run_mul("mul_after_rst", 4'd15, 1'b1);

    set_instr(2'b00, 6'b001001, 4'd1, 1'b0);
    step("final_fetch", fetch_v(2'b00));

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
